// File: rtl/mimo_frame_loader_pkg.sv
// mimo_frame_loader_pkg: shared sizes for the MIMO frame loader (word length WL defaults to 16 unless `WL is predefined)
`ifndef WL
`define WL 16
`endif
package mimo_frame_loader_pkg;
  localparam int N = 4;
  localparam int WL = `WL;
  localparam int FRAME_LEN = N * (N + 1);
  localparam int CW = $clog2(FRAME_LEN);
  localparam int RW = $clog2(N);
  localparam int COLW = $clog2(N + 1);
endpackage

// File: rtl/mimo_frame_loader_bank.sv
// loader_bank: one frame of storage, N rows x (N+1) complex words, written by (row, col), read as a packed row
module loader_bank
  import mimo_frame_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [RW-1:0]   wrow,
  input  logic [COLW-1:0] wcol,
  input  logic [WL-1:0]   wre,
  input  logic [WL-1:0]   wim,
  input  logic [RW-1:0]   rrow,
  output logic [WL*N-1:0] hx,
  output logic [WL*N-1:0] hy,
  output logic [WL-1:0]   yx,
  output logic [WL-1:0]   yy
);
  logic [WL-1:0] mx [N][N+1];
  logic [WL-1:0] my [N][N+1];
  always_ff @(posedge clk)
    if (rst) begin
      for (int r = 0; r < N; r++)
        for (int c = 0; c <= N; c++) begin
          mx[r][c] <= '0;
          my[r][c] <= '0;
        end
    end else if (we) begin
      mx[wrow][wcol] <= wre;
      my[wrow][wcol] <= wim;
    end
  for (genvar c = 0; c < N; c++) begin : g_col
    assign hx[WL*c +: WL] = mx[rrow][c];
    assign hy[WL*c +: WL] = my[rrow][c];
  end
  assign yx = mx[rrow][N];
  assign yy = my[rrow][N];
endmodule

// File: rtl/mimo_frame_loader.sv
// mimo_frame_loader: ping-pong frame assembly of H/y samples, drained one row per handshake.
// Define MIMO_LOADER_ERRCHK_EN to restart a frame on a misplaced in_sof and pulse err_sof.
module mimo_frame_loader
  import mimo_frame_loader_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_sof,
  input  logic [WL-1:0]   in_re,
  input  logic [WL-1:0]   in_im,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [WL*N-1:0] Hout_x,
  output logic [WL*N-1:0] Hout_y,
  output logic [WL-1:0]   yout_x,
  output logic [WL-1:0]   yout_y,
  output logic [RW-1:0]   out_row,
  output logic            out_last,
  output logic            err_sof
);
  logic [CW-1:0] cnt, wcnt;
  logic [1:0] full;
  logic wbank, rbank, acc, sof_err, wdone, rtake, rdone;
  logic [RW-1:0] rrow, wrow;
  logic [COLW-1:0] wcol;
  logic [WL*N-1:0] hx [2];
  logic [WL*N-1:0] hy [2];
  logic [WL-1:0] yx [2];
  logic [WL-1:0] yy [2];
  assign in_ready = !full[wbank];
  assign acc = in_valid && in_ready;
`ifdef MIMO_LOADER_ERRCHK_EN
  assign sof_err = acc && in_sof && cnt != '0;
`else
  assign sof_err = acc && in_sof && 1'b0;
`endif
  // a misplaced start-of-frame restarts the partial frame at element 0
  assign wcnt = sof_err ? '0 : cnt;
  assign wrow = RW'(wcnt / CW'(N + 1));
  assign wcol = COLW'(wcnt % CW'(N + 1));
  assign wdone = acc && wcnt == CW'(FRAME_LEN - 1);
  assign out_valid = full[rbank];
  assign rtake = out_valid && out_ready;
  assign rdone = rtake && rrow == RW'(N - 1);
  always_ff @(posedge clk)
    if (rst) begin
      cnt <= '0;
      rrow <= '0;
      wbank <= 1'b0;
      rbank <= 1'b0;
      full <= '0;
      err_sof <= 1'b0;
    end else begin
      if (acc) cnt <= wdone ? '0 : wcnt + 1'b1;
      if (wdone) wbank <= !wbank;
      if (rtake) rrow <= rdone ? '0 : rrow + 1'b1;
      if (rdone) rbank <= !rbank;
      full <= (full | ({1'b0, wdone} << wbank)) & ~({1'b0, rdone} << rbank);
      err_sof <= sof_err;
    end
  for (genvar b = 0; b < 2; b++) begin : g_bank
    loader_bank u_bank (
      .clk(clk), .rst(rst), .we(acc && wbank == b[0]),
      .wrow(wrow), .wcol(wcol), .wre(in_re), .wim(in_im),
      .rrow(rrow), .hx(hx[b]), .hy(hy[b]), .yx(yx[b]), .yy(yy[b])
    );
  end
  assign Hout_x = rbank ? hx[1] : hx[0];
  assign Hout_y = rbank ? hy[1] : hy[0];
  assign yout_x = rbank ? yx[1] : yx[0];
  assign yout_y = rbank ? yy[1] : yy[0];
  assign out_row = rrow;
  assign out_last = out_valid && rrow == RW'(N - 1);
endmodule

// File: tb/tb_mimo_frame_loader.sv
// tb_mimo_frame_loader: directed and randomized checks against a frame-queue reference model
module tb_mimo_frame_loader;
  logic clk = 0, rst = 1, in_valid = 0, in_sof = 0, out_ready = 0;
  logic [15:0] in_re = 0, in_im = 0;
  logic in_ready, out_valid, out_last, err_sof;
  logic [63:0] Hout_x, Hout_y;
  logic [15:0] yout_x, yout_y;
  logic [1:0] out_row;
  int checks = 0, errors = 0;

  typedef logic [31:0] frame_t [20];
  frame_t frames[$];
  logic [31:0] part[$];
  int rd = 0;
  logic err_exp = 0;

  mimo_frame_loader dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof),
    .in_re(in_re), .in_im(in_im), .out_valid(out_valid), .out_ready(out_ready),
    .Hout_x(Hout_x), .Hout_y(Hout_y), .yout_x(yout_x), .yout_y(yout_y),
    .out_row(out_row), .out_last(out_last), .err_sof(err_sof)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_all();
    frame_t f;
    logic [63:0] hx, hy;
    check("out_valid", out_valid, frames.size() > 0);
    check("in_ready", in_ready, frames.size() < 2);
    check("err_sof", err_sof, err_exp);
    if (frames.size() > 0) begin
      f = frames[0];
      for (int c = 0; c < 4; c++) begin
        hx[16*c +: 16] = f[rd*5+c][31:16];
        hy[16*c +: 16] = f[rd*5+c][15:0];
      end
      check("out_row", out_row, rd);
      check("out_last", out_last, rd == 3);
      check("Hout_x", Hout_x, hx);
      check("Hout_y", Hout_y, hy);
      check("yout_x", yout_x, f[rd*5+4][31:16]);
      check("yout_y", yout_y, f[rd*5+4][15:0]);
    end else
      check("out_last_idle", out_last, 0);
  endtask

  task automatic step(input logic v, input logic s, input logic [15:0] re, input logic [15:0] im,
                      input logic rdy);
    frame_t f;
    logic acc_m, take_m;
    in_valid = v; in_sof = s; in_re = re; in_im = im; out_ready = rdy;
    acc_m = v && frames.size() < 2;
    take_m = rdy && frames.size() > 0;
    err_exp = 0;
    @(posedge clk); #1;
    if (take_m) begin
      rd++;
      if (rd == 4) begin
        void'(frames.pop_front());
        rd = 0;
      end
    end
    if (acc_m) begin
`ifdef MIMO_LOADER_ERRCHK_EN
      if (s && part.size() != 0) begin
        part.delete();
        err_exp = 1;
      end
`endif
      part.push_back({re, im});
      if (part.size() == 20) begin
        for (int i = 0; i < 20; i++) f[i] = part[i];
        frames.push_back(f);
        part.delete();
      end
    end
    check_all();
  endtask

  task automatic do_reset();
    rst = 1; in_valid = 0; out_ready = 0; in_sof = 0;
    @(posedge clk); @(posedge clk); #1;
    rst = 0;
    frames.delete(); part.delete(); rd = 0; err_exp = 0;
    check("rst_Hout_x", Hout_x, 0);
    check("rst_yout_y", yout_y, 0);
    check("rst_out_row", out_row, 0);
    check_all();
  endtask

  task automatic ramp(input int from, input int count, input int sof_at, input logic rdy);
    int nk;
    logic [31:0] a, b;
    for (int k = from; k < from + count; k++) begin
      nk = -k; a = k; b = nk;
      step(1, k == sof_at, a[15:0], b[15:0], rdy);
    end
  endtask

  initial begin
    logic [31:0] r;
    do_reset();
    // single frame, sample k = (k, -k)
    ramp(0, 20, 0, 1);
    step(0, 0, 0, 0, 1);
    for (int c = 0; c < 4; c++) check("row1_H", Hout_x[16*c +: 16], 5 + c);
    check("row1_yx", yout_x, 9);
    check("row1_yy", yout_y, 16'hFFF7);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1);
    // back-to-back frames
    ramp(100, 40, 100, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    // stalled drain, three frames offered
    ramp(200, 60, 200, 0);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 0, 1);
    // reset mid-frame
    ramp(300, 8, 300, 1);
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    ramp(400, 20, 400, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    // misplaced start-of-frame on sample 10
    do_reset();
    ramp(0, 30, 10, 1);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 1);
    // extreme values in H[3][3] and y[3]
    do_reset();
    for (int k = 0; k < 20; k++) begin
      r = $urandom;
      if (k == 18) step(1, 0, 16'h8000, 16'h7FFF, 0);
      else if (k == 19) step(1, 0, 16'h7FFF, 16'h8000, 0);
      else step(1, k == 0, r[31:16], r[15:0], 0);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1);
    check("ext_H33x", Hout_x[63:48], 16'h8000);
    check("ext_H33y", Hout_y[63:48], 16'h7FFF);
    check("ext_yx", yout_x, 16'h7FFF);
    check("ext_yy", yout_y, 16'h8000);
    step(0, 0, 0, 0, 1);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, r[31:16], r[15:0],
           $urandom_range(0, 2) != 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/mimo_frame_loader.md
# mimo_frame_loader

Sequential input stage of the 4x4 MIMO detector, directly upstream of row normalization. Accepts one complex sample per handshake (channel matrix H and receive vector y, row-interleaved), assembles complete frames into a ping-pong buffer, and presents one complete row per cycle. Each presented row is the N packed H entries plus the matching y entry, which is what the row-normalization stage consumes. Loading of frame k+1 overlaps draining of frame k.

## Interface
- `N`, 4, antennas (rows/columns of H, length of y)
- `WL`, `` `WL `` from parameters.v (16), signed word length of one real component
- `clk` in 1: rising-edge clock
- `rst` in 1: synchronous, active-high reset
- `in_valid` in 1: input sample valid
- `in_ready` out 1: loader can accept a sample
- `in_sof` in 1: start-of-frame marker on the sample
- `in_re`, `in_im` in WL each: signed real/imag of the sample
- `out_valid` out 1: row available
- `out_ready` in 1: downstream takes the row
- `Hout_x`, `Hout_y` out WL*N: packed real/imag of H row; column c at bits [WL*c+WL-1 : WL*c]
- `yout_x`, `yout_y` out WL: real/imag of y[row]
- `out_row` out 2: row index 0..N-1
- `out_last` out 1: high with row N-1
- `err_sof` out 1: one-cycle framing-error pulse

## Operation
- Frame is FRAME_LEN = N*(N+1) = 20 samples, ordered row by row. Each row r carries H[r][0..N-1], then y[r].
- Write side:
  - Write element counter runs 0..19.
  - Row = cnt / (N+1); col = cnt % (N+1); col N means y.
  - A sample is accepted when `in_valid && in_ready` and is written to the bank selected by `wbank`.
  - On acceptance of element 19: set `full[wbank]`, toggle `wbank`, counter wraps to 0.
- `in_ready` = !full[wbank], combinational from registers.
- Read side:
  - `out_valid` = full[rbank].
  - Data outputs mux bank rbank at row `rrow`.
  - On `out_valid && out_ready`: rrow++.
  - At rrow = N-1 the handshake also clears `full[rbank]`, toggles `rbank`, and wraps rrow to 0.
- Simultaneous events:
  - Write completion on one bank and read release of the other in the same cycle both take effect.
  - Write and read never target the same bank, since write requires !full.
- Both banks full: `in_ready` = 0 until the read side releases a bank. `in_ready` rises the cycle after the releasing handshake.
- No arithmetic: samples are stored bit-exact and sign is preserved.
- Outputs are held stable while `out_valid && !out_ready`.

## Timing
- Reset (synchronous, one or more cycles of `rst`=1):
  - Counters, rrow, wbank, rbank and full flags go to 0.
  - Bank contents go to 0.
  - `out_valid` = 0, `out_last` = 0, `out_row` = 0, data outputs 0, `err_sof` = 0.
  - `in_ready` = 1 from the first cycle after reset.
- `rst` asserted mid-frame or mid-drain drops all partial and complete frames. No row is output afterwards until 20 new samples are accepted.
- Latency: element 19 accepted at edge t gives `out_valid` = 1 in the cycle after t.
- Throughput: 1 sample/cycle in; 1 row/cycle out; sustained 20 cycles per frame with no input stall when `out_ready` = 1.

## Configuration
- `MIMO_LOADER_ERRCHK_EN` defined:
  - An accepted sample with `in_sof` = 1 while the write counter is nonzero discards the partial frame in `wbank`.
  - That sample is stored as element 0 and the counter becomes 1.
  - `err_sof` pulses high for the cycle after acceptance.
  - `in_sof` = 1 at counter 0 is normal.
- Not defined: `in_sof` is ignored and `err_sof` is tied to 0.

## Structure
- Shared package/header, alongside `` `WL ``: N, FRAME_LEN, counter width ($clog2(FRAME_LEN)), row-index width.
- One sub-module, `loader_bank`:
  - Storage for one frame: N rows x (N+1) complex words.
  - Write port indexed by (row, col); read port returns a packed row.
  - Instantiated twice.
- Top level holds the counters, full flags, bank pointers and handshake logic.

## Test plan
- Single frame, sample k = (k, -k), `out_ready` = 1:
  - Rows 0..3 appear on consecutive cycles starting the cycle after element 19.
  - Row 1 gives Hout_x column c = 5+c, yout_x = 9, yout_y = -9.
  - `out_last` is high only on row 3.
- Back-to-back frames with `in_valid` held at 1 and `out_ready` = 1: `in_ready` never drops, and all 40 samples appear in order.
- `out_ready` = 0, three frames offered: `in_ready` falls after sample 40 and rises one cycle after the row-3 handshake of frame 1.
- `rst` pulsed after sample 7: no output; a fresh 20-sample frame then drains normally.
- With `MIMO_LOADER_ERRCHK_EN`, `in_sof` = 1 on sample 10: `err_sof` pulses once, and the output frame begins with the value of sample 10. Without the macro, the frame uses samples 0..19 and `err_sof` stays 0.
- Extreme values 0x8000 and 0x7FFF in H[3][3] and y[3]: reproduced bit-exact on row 3.
